// File: rtl/inst_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_queue_pkg
//   Shared types for the instruction queue that sits between instruction
//   fetch and the decoder.
//   Contents:
//     ID_W, PC_W      instruction word width and program-counter width
//     entry_t         one queue slot: {inst, pc}
//     upd_e           kind of pointer/count update applied at a clock edge
//     classify_update priority encoder that selects the upd_e for an edge
// ----------------------------------------------------------------------------
package inst_queue_pkg;

    localparam int ID_W = 32;
    localparam int PC_W = 32;

    typedef struct packed {
        logic [ID_W-1:0] inst;
        logic [PC_W-1:0] pc;
    } entry_t;

    typedef enum logic [2:0] {
        UPD_HOLD,   // nothing moves
        UPD_CLEAR,  // flush: head = tail = count = 0
        UPD_PUSH,   // enqueue only
        UPD_POP,    // dequeue only
        UPD_BOTH    // enqueue and dequeue in the same cycle
    } upd_e;

    // Flushes outrank normal traffic. A ROB flush always wins; a decoder
    // redirect only takes effect on a cycle where the head is really
    // consumed, because the JAL it refers to is that head entry.
    function automatic upd_e classify_update(
        input logic rdy,
        input logic rob_flush,
        input logic jal_flush,
        input logic push,
        input logic pop
    );
        upd_e kind;
        kind = UPD_HOLD;
        if (!rdy)               kind = UPD_HOLD;
        else if (rob_flush)     kind = UPD_CLEAR;
        else if (jal_flush)     kind = UPD_CLEAR;
        else if (push && pop)   kind = UPD_BOTH;
        else if (push)          kind = UPD_PUSH;
        else if (pop)           kind = UPD_POP;
        return kind;
    endfunction

endpackage : inst_queue_pkg

// File: rtl/inst_queue_if.sv
// ----------------------------------------------------------------------------
// inst_queue_if
//   Bundles every non-clock/reset signal of the instruction queue.
//   Modports:
//     master  the surrounding core (IF, decoder, dispatcher, ROB)
//     slave   the instruction queue itself
//   Signals:
//     if_instqueue_en_in             IF presents a fetched instruction
//     if_instqueue_inst_in           fetched instruction word
//     if_instqueue_pc_in             pc of the fetched instruction
//     instqueue_if_full_out          queue full; IF must not push
//     instqueue_decoder_en_out       head entry valid and consumed this cycle
//     instqueue_decoder_inst_out     head instruction word (show-ahead)
//     instqueue_decoder_pc_out       head pc (show-ahead)
//     decoder_instqueue_rst_in       decoder saw JAL in head; drop younger
//     dispatcher_instqueue_stall_in  downstream back-pressure; hold head
//     rob_instqueue_rst_in           mispredict/exception flush
// ----------------------------------------------------------------------------
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic            if_instqueue_en_in;
    logic [ID_W-1:0] if_instqueue_inst_in;
    logic [PC_W-1:0] if_instqueue_pc_in;
    logic            instqueue_if_full_out;
    logic            instqueue_decoder_en_out;
    logic [ID_W-1:0] instqueue_decoder_inst_out;
    logic [PC_W-1:0] instqueue_decoder_pc_out;
    logic            decoder_instqueue_rst_in;
    logic            dispatcher_instqueue_stall_in;
    logic            rob_instqueue_rst_in;

    modport master (
        output if_instqueue_en_in,
        output if_instqueue_inst_in,
        output if_instqueue_pc_in,
        input  instqueue_if_full_out,
        input  instqueue_decoder_en_out,
        input  instqueue_decoder_inst_out,
        input  instqueue_decoder_pc_out,
        output decoder_instqueue_rst_in,
        output dispatcher_instqueue_stall_in,
        output rob_instqueue_rst_in
    );

    modport slave (
        input  if_instqueue_en_in,
        input  if_instqueue_inst_in,
        input  if_instqueue_pc_in,
        output instqueue_if_full_out,
        output instqueue_decoder_en_out,
        output instqueue_decoder_inst_out,
        output instqueue_decoder_pc_out,
        input  decoder_instqueue_rst_in,
        input  dispatcher_instqueue_stall_in,
        input  rob_instqueue_rst_in
    );

endinterface : inst_queue_if

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
//   Circular instruction buffer between instruction fetch and the decoder.
//   Accepts one {inst, pc} per cycle from IF and presents the oldest entry to
//   the decoder (show-ahead). Holds on dispatcher back-pressure and flushes on
//   a decoder JAL redirect or a ROB mispredict.
//   Parameters:
//     DEPTH   number of entries (power of two, >= 2)
//     ADDR_W  log2(DEPTH); pointer width, count is ADDR_W+1 bits
//   Ports:
//     clk_in  clock, all state changes on the rising edge
//     rst_in  synchronous active-high reset, highest priority
//     rdy_in  global ready; low freezes all state
//     q       inst_queue_if.slave (IF / decoder / dispatcher / ROB signals)
// ----------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    inst_queue_if.slave  q
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    entry_t            storage_q [DEPTH];
    logic [ADDR_W-1:0] head_q,  head_d;
    logic [ADDR_W-1:0] tail_q,  tail_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic   full;
    logic   nonempty;
    logic   pop;
    logic   push;
    logic   jal_flush;
    upd_e   upd;
    entry_t wr_entry;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign full     = (count_q == FULL_COUNT);
    assign nonempty = (count_q != '0);

    // The decoder's redirect is computed from en_out, so pop must never
    // look at decoder_instqueue_rst_in or a combinational loop forms.
    assign pop = !rst_in && rdy_in && nonempty
              && !q.dispatcher_instqueue_stall_in
              && !q.rob_instqueue_rst_in;

    // A push into a full queue is still legal when the head leaves in the
    // same cycle; otherwise it is an IF protocol violation and is dropped.
    assign push = !rst_in && rdy_in && q.if_instqueue_en_in && (!full || pop);

    assign jal_flush = pop && q.decoder_instqueue_rst_in;

    assign upd = classify_update(rdy_in, q.rob_instqueue_rst_in,
                                 jal_flush, push, pop);

    assign wr_entry = '{inst: q.if_instqueue_inst_in,
                        pc:   q.if_instqueue_pc_in};

    // ------------------------------------------------------------------
    // Pointer / count next state
    // ------------------------------------------------------------------
    // NOTE: every variable written here gets a default first so no latch
    // is inferred for update kinds that leave it untouched.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (upd)
            UPD_CLEAR: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
            UPD_PUSH: begin
                tail_d  = tail_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end
            UPD_POP: begin
                head_d  = head_q + PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
            UPD_BOTH: begin
                head_d  = head_q + PTR_ONE;
                tail_d  = tail_q + PTR_ONE;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is
    // tracked by count_q alone, so stale slots are never observed.
    // Writes that coincide with a flush land in a slot that the cleared
    // pointers immediately treat as free.
    always_ff @(posedge clk_in) begin
        if (push) begin
            storage_q[tail_q] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign q.instqueue_decoder_en_out   = pop;
    assign q.instqueue_decoder_inst_out = storage_q[head_q].inst;
    assign q.instqueue_decoder_pc_out   = storage_q[head_q].pc;
    assign q.instqueue_if_full_out      = !rst_in && full;

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// ----------------------------------------------------------------------------
// tb_inst_queue
//   Self-checking bench for inst_queue. A queue of {inst, pc} records models
//   the buffer; every cycle the DUT outputs are compared against it. A table
//   of hand-derived vectors, directed corner sequences and a random run all
//   go through the same per-cycle task.
// ----------------------------------------------------------------------------
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int QDEPTH = 16;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    inst_queue_if bus ();

    inst_queue #(.DEPTH(QDEPTH), .ADDR_W(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .q      (bus)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        if_en;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        dec_rst;
        logic        stall;
        logic        rob_rst;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_en;
        logic        exp_full;
        logic [31:0] exp_pc;
    } vec_t;

    entry_t mq[$];
    int     tests = 0;
    int     fails = 0;
    string  phase = "init";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %h, expected %h (t=%0t)", phase, name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic rst, input logic rdy, input logic en,
                                 input logic [31:0] pc, input logic dec,
                                 input logic stall, input logic rob);
        stim_t s;
        s.rst     = rst;
        s.rdy     = rdy;
        s.if_en   = en;
        s.pc      = pc;
        s.inst    = pc ^ 32'hA5A5_0013;
        s.dec_rst = dec;
        s.stall   = stall;
        s.rob_rst = rob;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic en, input logic full,
                                 input logic [31:0] pc);
        vec_t v;
        v.s        = s;
        v.exp_en   = en;
        v.exp_full = full;
        v.exp_pc   = pc;
        return v;
    endfunction

    // Model prediction of whether the head is consumed this cycle.
    function automatic logic model_pop(input stim_t s);
        return !s.rst && s.rdy && (mq.size() != 0) && !s.stall && !s.rob_rst;
    endfunction

    // Apply one cycle: drive, compare against the model, clock, update model.
    task automatic cycle(input stim_t s, output logic o_en, output logic o_full,
                         output logic [31:0] o_pc);
        logic exp_en;
        logic exp_full;
        bit   had_room;
        rst_in                            = s.rst;
        rdy_in                            = s.rdy;
        bus.if_instqueue_en_in            = s.if_en;
        bus.if_instqueue_inst_in          = s.inst;
        bus.if_instqueue_pc_in            = s.pc;
        bus.decoder_instqueue_rst_in      = s.dec_rst;
        bus.dispatcher_instqueue_stall_in = s.stall;
        bus.rob_instqueue_rst_in          = s.rob_rst;
        #1;
        exp_en   = model_pop(s);
        exp_full = !s.rst && (mq.size() == QDEPTH);
        o_en     = bus.instqueue_decoder_en_out;
        o_full   = bus.instqueue_if_full_out;
        o_pc     = bus.instqueue_decoder_pc_out;
        check("en", 64'(o_en), 64'(exp_en));
        check("full", 64'(o_full), 64'(exp_full));
        if (exp_en) begin
            check("pc", 64'(o_pc), 64'(mq[0].pc));
            check("inst", 64'(bus.instqueue_decoder_inst_out), 64'(mq[0].inst));
        end
        @(posedge clk_in);
        if (s.rst) begin
            mq.delete();
        end else if (s.rdy) begin
            if (s.rob_rst || (exp_en && s.dec_rst)) begin
                mq.delete();
            end else begin
                had_room = mq.size() < QDEPTH;
                if (exp_en) void'(mq.pop_front());
                if (s.if_en && (had_room || exp_en))
                    mq.push_back('{inst: s.inst, pc: s.pc});
            end
        end
        #1;
    endtask

    initial begin
        vec_t        tbl[$];
        stim_t       s;
        logic        o_en;
        logic        o_full;
        logic [31:0] o_pc;

        s = mk(1, 1, 0, 0, 0, 0, 0);
        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.if_instqueue_en_in            = 1'b0;
        bus.if_instqueue_inst_in          = '0;
        bus.if_instqueue_pc_in            = '0;
        bus.decoder_instqueue_rst_in      = 1'b0;
        bus.dispatcher_instqueue_stall_in = 1'b0;
        bus.rob_instqueue_rst_in          = 1'b0;
        @(posedge clk_in);
        #1;

        // ---------------- table of hand-derived vectors -----------------
        //                  rst rdy en  pc        dec stl rob     en full pc
        tbl.push_back(mkv(mk(1, 1, 1, 32'h500, 0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(1, 1, 1, 32'h504, 0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 1, 32'h10,  0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 1, 0, 32'h10));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 1, 32'h20,  0, 1, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 1, 32'h24,  0, 1, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 1, 0, 32'h20));
        tbl.push_back(mkv(mk(0, 0, 0, 32'h0,   0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 1, 0, 32'h24));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 1, 32'h30,  0, 0, 1), 0, 0, 32'h0));
        tbl.push_back(mkv(mk(0, 1, 0, 32'h0,   0, 0, 0), 0, 0, 32'h0));
        phase = "table";
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].s, o_en, o_full, o_pc);
            check($sformatf("row%0d_en", i), 64'(o_en), 64'(tbl[i].exp_en));
            check($sformatf("row%0d_full", i), 64'(o_full), 64'(tbl[i].exp_full));
            if (tbl[i].exp_en)
                check($sformatf("row%0d_pc", i), 64'(o_pc), 64'(tbl[i].exp_pc));
        end

        // ---------------- fill / drain ----------------------------------
        phase = "fill";
        for (int i = 0; i < QDEPTH; i++) begin
            cycle(mk(0, 1, 1, 32'(i * 4), 0, 1, 0), o_en, o_full, o_pc);
            check("not_full_yet", 64'(o_full), 64'(0));
        end
        // 17th push while full and stalled: must be dropped.
        cycle(mk(0, 1, 1, 32'h40, 0, 1, 0), o_en, o_full, o_pc);
        check("full_after_16", 64'(o_full), 64'(1));
        phase = "drain";
        for (int i = 0; i < QDEPTH; i++) begin
            cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
            check($sformatf("pop%0d_en", i), 64'(o_en), 64'(1));
            check($sformatf("pop%0d_pc", i), 64'(o_pc), 64'(i * 4));
        end
        cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
        check("dropped_17th", 64'(o_en), 64'(0));

        // ---------------- wrap: 40 push+pop -----------------------------
        phase = "wrap";
        for (int k = 0; k < 40; k++) begin
            cycle(mk(0, 1, 1, 32'h1000 + 32'(k * 4), 0, 0, 0), o_en, o_full, o_pc);
            check($sformatf("w%0d_en", k), 64'(o_en), 64'(k != 0));
            if (k != 0) check($sformatf("w%0d_pc", k), 64'(o_pc), 64'(32'h1000 + 32'((k - 1) * 4)));
        end
        cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
        check("wrap_last_pc", 64'(o_pc), 64'(32'h109C));
        cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
        check("wrap_empty", 64'(o_en), 64'(0));

        // ---------------- decoder JAL flush -----------------------------
        phase = "jal";
        s = mk(0, 1, 1, 32'h100, 0, 1, 0);
        s.inst = 32'h0080_006F;
        cycle(s, o_en, o_full, o_pc);
        cycle(mk(0, 1, 1, 32'h104, 0, 1, 0), o_en, o_full, o_pc);
        cycle(mk(0, 1, 1, 32'h108, 0, 1, 0), o_en, o_full, o_pc);
        cycle(mk(0, 1, 1, 32'h10C, 1, 0, 0), o_en, o_full, o_pc);
        check("jal_pop_en", 64'(o_en), 64'(1));
        check("jal_pop_pc", 64'(o_pc), 64'(32'h100));
        cycle(mk(0, 1, 1, 32'h180, 0, 0, 0), o_en, o_full, o_pc);
        check("jal_after_empty", 64'(o_en), 64'(0));
        cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
        check("jal_new_en", 64'(o_en), 64'(1));
        check("jal_new_pc", 64'(o_pc), 64'(32'h180));

        // ---------------- ROB flush -------------------------------------
        phase = "rob";
        for (int i = 0; i < 5; i++)
            cycle(mk(0, 1, 1, 32'h200 + 32'(i * 4), 0, 1, 0), o_en, o_full, o_pc);
        cycle(mk(0, 1, 1, 32'h300, 0, 0, 1), o_en, o_full, o_pc);
        check("rob_en_low", 64'(o_en), 64'(0));
        cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
        check("rob_empty", 64'(o_en), 64'(0));

        // ---------------- full + push/pop, then rdy low -----------------
        phase = "fullrdy";
        for (int i = 0; i < QDEPTH; i++)
            cycle(mk(0, 1, 1, 32'h400 + 32'(i * 4), 0, 1, 0), o_en, o_full, o_pc);
        cycle(mk(0, 1, 1, 32'h440, 0, 0, 0), o_en, o_full, o_pc);
        check("both_at_full_en", 64'(o_en), 64'(1));
        check("both_at_full_pc", 64'(o_pc), 64'(32'h400));
        for (int i = 0; i < 3; i++) begin
            cycle(mk(0, 0, 1, 32'h600, 0, 0, 0), o_en, o_full, o_pc);
            check($sformatf("rdy0_%0d_en", i), 64'(o_en), 64'(0));
            check($sformatf("rdy0_%0d_full", i), 64'(o_full), 64'(1));
        end
        for (int i = 0; i < QDEPTH; i++) begin
            cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
            check($sformatf("fd%0d_pc", i), 64'(o_pc), 64'(32'h404 + 32'(i * 4)));
        end
        cycle(mk(0, 1, 0, 0, 0, 0, 0), o_en, o_full, o_pc);
        check("fullrdy_empty", 64'(o_en), 64'(0));

        // ---------------- random against the model ----------------------
        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            s = mk(($urandom_range(63) == 0), ($urandom_range(7) != 0),
                   $urandom_range(1) == 1, $urandom, 0,
                   ($urandom_range(3) == 0), ($urandom_range(31) == 0));
            s.inst = $urandom;
            if (mq.size() == QDEPTH && !model_pop(s)) s.if_en = 1'b0;
            if (model_pop(s) && $urandom_range(15) == 0) s.dec_rst = 1'b1;
            cycle(s, o_en, o_full, o_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_inst_queue
